// File: rtl/e_m_pipe_reg_if.sv
// E->M pipeline register bus: E-stage fields in, M-stage fields and forwarding source out.
// The master drives the E side and observes M; the slave is the pipeline register itself.
interface e_m_pipe_reg_if;
   logic        en;
   logic        flush;
   logic [31:0] E_PC;
   logic [31:0] E_Instr;
   logic [31:0] E_ALUOut;
   logic [31:0] E_RTData;
   logic [4:0]  E_A3;
   logic [1:0]  E_WDSel;
   logic        E_RegWrite;
   logic        E_MemWrite;
   logic [1:0]  E_Tnew;
   logic [31:0] M_PC;
   logic [31:0] M_Instr;
   logic [31:0] M_ALUOut;
   logic [31:0] M_RTData;
   logic [4:0]  M_A3;
   logic [1:0]  M_WDSel;
   logic        M_RegWrite;
   logic        M_MemWrite;
   logic [1:0]  M_Tnew;
   logic [31:0] M_FwdData;
   logic        M_FwdValid;

   modport master (
      output en, flush, E_PC, E_Instr, E_ALUOut, E_RTData, E_A3, E_WDSel,
             E_RegWrite, E_MemWrite, E_Tnew,
      input  M_PC, M_Instr, M_ALUOut, M_RTData, M_A3, M_WDSel, M_RegWrite,
             M_MemWrite, M_Tnew, M_FwdData, M_FwdValid
   );

   modport slave (
      input  en, flush, E_PC, E_Instr, E_ALUOut, E_RTData, E_A3, E_WDSel,
             E_RegWrite, E_MemWrite, E_Tnew,
      output M_PC, M_Instr, M_ALUOut, M_RTData, M_A3, M_WDSel, M_RegWrite,
             M_MemWrite, M_Tnew, M_FwdData, M_FwdValid
   );
endinterface

// File: rtl/e_m_pipe_reg.sv
// E->M pipeline register of the 5-stage MIPS core: latches ALU result, store data and
// write-back control, ages Tnew, bubbles on flush and exports the M-stage forwarding source.
module e_m_pipe_reg #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [1:0]  WDSEL_ALU = 2'd0,
   parameter logic [1:0]  WDSEL_MEM = 2'd1,
   parameter logic [1:0]  WDSEL_PC8 = 2'd2
) (
   input logic                clk,
   input logic                reset,
   e_m_pipe_reg_if.slave      bus
);

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_aluout;
   logic [31:0] m_rtdata;
   logic [4:0]  m_a3;
   logic [1:0]  m_wdsel;
   logic        m_regwrite;
   logic        m_memwrite;
   logic [1:0]  m_tnew;

   logic        rw_next;
   logic [1:0]  tnew_next;

   // Writes to $0 are dropped here so $0 can never match a forwarding request.
   assign rw_next   = bus.E_RegWrite & (bus.E_A3 != 5'd0);
   assign tnew_next = (bus.E_Tnew == 2'd0) ? 2'd0 : bus.E_Tnew - 2'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_pc       <= PC_RESET;
         m_instr    <= '0;
         m_aluout   <= '0;
         m_rtdata   <= '0;
         m_a3       <= '0;
         m_wdsel    <= WDSEL_ALU;
         m_regwrite <= 1'b0;
         m_memwrite <= 1'b0;
         m_tnew     <= '0;
      end else if (bus.flush) begin
         // Bubble keeps the PC for later EPC use.
         m_pc       <= bus.E_PC;
         m_instr    <= '0;
         m_aluout   <= '0;
         m_rtdata   <= '0;
         m_a3       <= '0;
         m_wdsel    <= WDSEL_ALU;
         m_regwrite <= 1'b0;
         m_memwrite <= 1'b0;
         m_tnew     <= '0;
      end else if (bus.en) begin
         m_pc       <= bus.E_PC;
         m_instr    <= bus.E_Instr;
         m_aluout   <= bus.E_ALUOut;
         m_rtdata   <= bus.E_RTData;
         m_a3       <= rw_next ? bus.E_A3 : 5'd0;
         m_wdsel    <= bus.E_WDSel;
         m_regwrite <= rw_next;
         m_memwrite <= bus.E_MemWrite;
         m_tnew     <= tnew_next;
      end
   end

   assign bus.M_PC       = m_pc;
   assign bus.M_Instr    = m_instr;
   assign bus.M_ALUOut   = m_aluout;
   assign bus.M_RTData   = m_rtdata;
   assign bus.M_A3       = m_a3;
   assign bus.M_WDSel    = m_wdsel;
   assign bus.M_RegWrite = m_regwrite;
   assign bus.M_MemWrite = m_memwrite;
   assign bus.M_Tnew     = m_tnew;

   // Forwarding is driven from registers only; code 3 falls through to the ALU result.
   assign bus.M_FwdData  = (m_wdsel == WDSEL_PC8) ? m_pc + 32'd8 : m_aluout;
   assign bus.M_FwdValid = m_regwrite & (m_tnew == 2'd0) & (m_wdsel != WDSEL_MEM);

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// Self-checking bench for e_m_pipe_reg: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the M-stage contents.
module tb_e_m_pipe_reg;
   logic clk = 1'b0;
   logic reset;

   e_m_pipe_reg_if bus();

   e_m_pipe_reg #(
      .PC_RESET  (32'h0000_3000),
      .WDSEL_ALU (2'd0),
      .WDSEL_MEM (2'd1),
      .WDSEL_PC8 (2'd2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model of what the M stage should hold.
   logic [31:0] x_pc, x_instr, x_alu, x_rt;
   logic [4:0]  x_a3;
   logic [1:0]  x_wdsel, x_tnew;
   logic        x_rw, x_mw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] a3, input logic [1:0] wdsel,
                         input logic rw, input logic mw, input logic [1:0] tnew);
      bus.E_PC       = pc;
      bus.E_Instr    = instr;
      bus.E_ALUOut   = alu;
      bus.E_RTData   = rt;
      bus.E_A3       = a3;
      bus.E_WDSel    = wdsel;
      bus.E_RegWrite = rw;
      bus.E_MemWrite = mw;
      bus.E_Tnew     = tnew;
   endtask

   task automatic model_edge();
      if (reset) begin
         x_pc = 32'h0000_3000;
         {x_instr, x_alu, x_rt} = '0;
         x_a3 = 0; x_wdsel = 0; x_tnew = 0; x_rw = 0; x_mw = 0;
      end else if (bus.flush) begin
         x_pc = bus.E_PC;
         {x_instr, x_alu, x_rt} = '0;
         x_a3 = 0; x_wdsel = 0; x_tnew = 0; x_rw = 0; x_mw = 0;
      end else if (bus.en) begin
         x_pc    = bus.E_PC;
         x_instr = bus.E_Instr;
         x_alu   = bus.E_ALUOut;
         x_rt    = bus.E_RTData;
         x_wdsel = bus.E_WDSel;
         x_mw    = bus.E_MemWrite;
         x_rw    = bus.E_RegWrite && (bus.E_A3 != 0);
         x_a3    = x_rw ? bus.E_A3 : 5'd0;
         x_tnew  = (bus.E_Tnew > 0) ? 2'(int'(bus.E_Tnew) - 1) : 2'd0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] fdata;
      logic        fvalid;
      fdata  = (x_wdsel == 2'd2) ? x_pc + 32'd8 : x_alu;
      fvalid = x_rw && (x_tnew == 0) && (x_wdsel != 2'd1);
      chk({tag, ".pc"},     bus.M_PC,       x_pc);
      chk({tag, ".instr"},  bus.M_Instr,    x_instr);
      chk({tag, ".alu"},    bus.M_ALUOut,   x_alu);
      chk({tag, ".rt"},     bus.M_RTData,   x_rt);
      chk({tag, ".a3"},     32'(bus.M_A3),  32'(x_a3));
      chk({tag, ".wdsel"},  32'(bus.M_WDSel), 32'(x_wdsel));
      chk({tag, ".rw"},     32'(bus.M_RegWrite), 32'(x_rw));
      chk({tag, ".mw"},     32'(bus.M_MemWrite), 32'(x_mw));
      chk({tag, ".tnew"},   32'(bus.M_Tnew), 32'(x_tnew));
      chk({tag, ".fdata"},  bus.M_FwdData,  fdata);
      chk({tag, ".fvalid"}, 32'(bus.M_FwdValid), 32'(fvalid));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1; bus.en = 1'b0; bus.flush = 1'b0;
      set_in(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0);
      tick("reset");
      chk("reset.pc_const", bus.M_PC, 32'h0000_3000);

      reset = 1'b0; bus.en = 1'b1;
      set_in(32'h3000, 32'h00a52821, 32'h12345678, 32'h0, 5'd5, 2'd0, 1'b1, 1'b0, 2'd1);
      tick("addu");
      chk("addu.fdata_const", bus.M_FwdData, 32'h12345678);
      chk("addu.fvalid_const", 32'(bus.M_FwdValid), 32'd1);

      set_in(32'h3004, 32'h8c880004, 32'h0000_1004, 32'h0, 5'd8, 2'd1, 1'b1, 1'b0, 2'd2);
      tick("lw");
      chk("lw.tnew_const", 32'(bus.M_Tnew), 32'd1);

      set_in(32'h3010, 32'h0c000c10, 32'h0, 32'h0, 5'd31, 2'd2, 1'b1, 1'b0, 2'd0);
      tick("jal");
      chk("jal.fdata_const", bus.M_FwdData, 32'h3018);

      set_in(32'hFFFF_FFFC, 32'h0c000000, 32'h0, 32'h0, 5'd31, 2'd2, 1'b1, 1'b0, 2'd0);
      tick("pc8wrap");

      set_in(32'h3014, 32'h00000821, 32'hDEAD_BEEF, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      tick("a3zero");

      set_in(32'h3018, 32'h00000000, 32'h5555_AAAA, 32'h1, 5'd9, 2'd3, 1'b1, 1'b0, 2'd0);
      tick("wdsel3");

      set_in(32'h301C, 32'h01095021, 32'h0000_0042, 32'h7, 5'd10, 2'd0, 1'b1, 1'b0, 2'd3);
      tick("stall_load");
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 2'($urandom));
         tick("stall");
      end
      chk("stall.tnew_const", 32'(bus.M_Tnew), 32'd2);

      bus.flush = 1'b1;
      set_in(32'h3020, 32'h12345678, 32'h1, 32'h2, 5'd3, 2'd0, 1'b1, 1'b1, 2'd1);
      tick("flush_stall");
      chk("flush_stall.pc_const", bus.M_PC, 32'h3020);

      bus.flush = 1'b0; bus.en = 1'b1;
      tick("reload");
      reset = 1'b1; bus.flush = 1'b1; bus.en = 1'b0;
      tick("rst_flush_stall");
      chk("rst_flush_stall.pc_const", bus.M_PC, 32'h0000_3000);

      reset = 1'b0; bus.flush = 1'b0; bus.en = 1'b1;
      set_in(32'h3024, 32'hac880008, 32'h0000_1008, 32'hCAFE_F00D, 5'd0, 2'd0, 1'b0, 1'b1, 2'd0);
      tick("sw");
      bus.flush = 1'b1;
      tick("sw_flush");

      bus.flush = 1'b0;
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 31) == 0);
         bus.flush = ($urandom_range(0, 9) == 0);
         bus.en    = ($urandom_range(0, 3) != 0);
         set_in($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 2'($urandom));
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
